// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer for an RV32I-subset core.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB and
// drives the IR / register file / PC / data memory strobes.
//
// Build option: define ILLEGAL_TRAP_EN to trap illegal instructions into a
// sticky HALT state. Without it, an illegal instruction retires as a NOP.
//
// Handshake: imem_req/dmem_req stay high from entry into FETCH/MEM until the
// cycle in which the matching ack is sampled high; that cycle completes the
// transfer and the state advances on the following edge. Acks seen outside
// their state are ignored. Wait states are unbounded.
module cpu_control_fsm #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         instr_opcode,
  input  logic [2:0]         instr_funct3,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               branch_cond,
  output logic               imem_req,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               rf_we,
  output logic               pc_load,
  output logic [1:0]         pc_src,
  output logic [1:0]         wb_sel,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_EXECUTE = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM     = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_WB      = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_HALT    = STATE_W'(5);

  typedef enum logic [3:0] {
    C_R, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
    C_JAL, C_JALR, C_LUI, C_AUIPC, C_NONE
  } cls_e;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  cls_e               dec_cls;
  cls_e               cls_q;
  logic               dec_illegal;

  assign state = state_q;

  // Classify the latched opcode and flag unlisted opcodes / bad funct3.
  always_comb begin
    dec_cls     = C_NONE;
    dec_illegal = 1'b0;
    case (instr_opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_NONE;
    endcase
    case (dec_cls)
      C_NONE:   dec_illegal = 1'b1;
      C_LOAD:   dec_illegal = (instr_funct3 == 3'b011) || (instr_funct3[2:1] == 2'b11);
      C_STORE:  dec_illegal = (instr_funct3 >= 3'b011);
      C_BRANCH: dec_illegal = (instr_funct3[2:1] == 2'b01);
      C_JALR:   dec_illegal = (instr_funct3 != 3'b000);
      default:  dec_illegal = 1'b0;
    endcase
  end

  // Hold the instruction class from DECODE for use in later states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q <= C_NONE;
    end else if (state_q == S_DECODE) begin
      cls_q <= dec_cls;
    end
  end

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (cls_q)
          C_BRANCH:        state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes per state; rst forces every output low in the same instant.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_load  = 1'b0;
    pc_src   = 2'b00;
    wb_sel   = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        // Illegal instruction retires as a NOP: advance PC by 4.
        illegal = dec_illegal;
        pc_load = dec_illegal;
`endif
      end
      S_EXECUTE: begin
        if (cls_q == C_BRANCH) begin
          pc_load = 1'b1;
          pc_src  = branch_cond ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        pc_load  = (cls_q == C_STORE) && dmem_ack;
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_load = 1'b1;
        case (cls_q)
          C_LOAD:  wb_sel = 2'b01;
          C_JAL:   begin wb_sel = 2'b10; pc_src = 2'b01; end
          C_JALR:  begin wb_sel = 2'b10; pc_src = 2'b10; end
          default: wb_sel = 2'b00;
        endcase
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
      default: ;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_load  = 1'b0;
      pc_src   = 2'b00;
      wb_sel   = 2'b00;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Testbench for cpu_control_fsm: directed and random instructions are turned
// into a per-cycle trace of inputs and expected outputs from the instruction
// timing rules, then played against the DUT cycle by cycle.
module tb_cpu_control_fsm;

  localparam int W = 14;

  // Instruction classes as the bench sees them.
  localparam int K_R = 0, K_OPIMM = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] instr_opcode;
  logic [2:0] instr_funct3;
  logic       imem_ack, dmem_ack, branch_cond;
  logic       imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_load, illegal;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cpu_control_fsm #(.STATE_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_opcode (instr_opcode),
    .instr_funct3 (instr_funct3),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .branch_cond  (branch_cond),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .rf_we        (rf_we),
    .pc_load      (pc_load),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal)
  );

  logic [W-1:0] obs;
  assign obs = {state, imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_load, pc_src, wb_sel, illegal};

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [2:0]   stim_q[$];   // {imem_ack, dmem_ack, branch_cond}

  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic ireq, input logic irl,
                                      input logic dreq, input logic dwe, input logic rfwe,
                                      input logic pcl, input logic [1:0] psrc,
                                      input logic [1:0] wsel, input logic ill);
    return {st, ireq, irl, dreq, dwe, rfwe, pcl, psrc, wsel, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_OPIMM;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic bit legal(input int k, input logic [2:0] f3);
    case (k)
      K_BAD:    return 1'b0;
      K_LOAD:   return !(f3 inside {3'd3, 3'd6, 3'd7});
      K_STORE:  return f3 <= 3'd2;
      K_BRANCH: return !(f3 inside {3'd2, 3'd3});
      K_JALR:   return f3 == 3'd0;
      default:  return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [2:0] stim, input logic [W-1:0] e);
    stim_q.push_back(stim);
    exp_q.push_back(e);
  endtask

  // Expected trace of one instruction from its class and the wait counts.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic bc,
                       input int iw, input int dw);
    int k;
    logic st_i, ld_i;
    logic [1:0] ws, ps;
    k = classify(op);
    st_i = (k == K_STORE);
    ld_i = (k == K_LOAD);
    for (int i = 0; i <= iw; i++)
      push({i == iw, rb(), rb()}, pk(3'd0, 1'b1, i == iw, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    if (!legal(k, f3)) begin
`ifdef ILLEGAL_TRAP_EN
      push({rb(), rb(), rb()}, pk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
      for (int i = 0; i < 20; i++)
        push({rb(), rb(), rb()}, pk(3'd5, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1'b1));
`else
      push({rb(), rb(), rb()}, pk(3'd1, 0, 0, 0, 0, 0, 1'b1, 2'd0, 2'd0, 1'b1));
`endif
      return;
    end
    push({rb(), rb(), rb()}, pk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    if (k == K_BRANCH) begin
      push({rb(), rb(), bc}, pk(3'd2, 0, 0, 0, 0, 0, 1'b1, bc ? 2'd1 : 2'd0, 2'd0, 0));
      return;
    end
    push({rb(), rb(), rb()}, pk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    if (st_i || ld_i) begin
      for (int i = 0; i <= dw; i++)
        push({rb(), i == dw, rb()}, pk(3'd3, 0, 0, 1'b1, st_i, 0, st_i && (i == dw), 2'd0, 2'd0, 0));
      if (st_i) return;
    end
    ws = ld_i ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
    ps = (k == K_JAL) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
    push({rb(), rb(), rb()}, pk(3'd4, 0, 0, 0, 0, 1'b1, 1'b1, ps, ws, 0));
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_steps(input string tag, input int limit, output int pcl);
    logic [2:0]   s;
    logic [W-1:0] e;
    int n;
    n   = 0;
    pcl = 0;
    while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      imem_ack    = s[2];
      dmem_ack    = s[1];
      branch_cond = s[0];
      @(negedge clk);
      check($sformatf("%s step%0d", tag, n), obs, e);
      if (pc_load === 1'b1) pcl++;
      @(posedge clk);
      #1;
      n++;
    end
    exp_q.delete();
    stim_q.delete();
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, " outputs"}, obs, '0);
    @(posedge clk);
    #1;
    check({tag, " held"}, obs, '0);
    rst = 1'b0;
  endtask

  task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic bc, input int iw, input int dw);
    int pcl;
    bit ill;
    ill = !legal(classify(op), f3);
    instr_opcode = op;
    instr_funct3 = f3;
    build(op, f3, bc, iw, dw);
    run_steps(tag, -1, pcl);
`ifdef ILLEGAL_TRAP_EN
    if (ill) begin
      check({tag, " pc_load count"}, W'(pcl), W'(0));
      apply_reset({tag, " trap reset"});
      return;
    end
`endif
    check({tag, " pc_load count"}, W'(pcl), W'(1));
    if (ill) check({tag, " back to fetch"}, W'(state), W'(0));
  endtask

  logic [6:0] ops [11];
  int pcl_dummy;

  // ---------------- directed + random sequence ----------------
  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000, 7'b1111111};
    rst = 1'b0;
    instr_opcode = '0;
    instr_funct3 = '0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    branch_cond = 1'b0;
    #1;
    apply_reset("por");

    do_instr("add",       7'b0110011, 3'b000, 0, 0, 0);
    do_instr("lw",        7'b0000011, 3'b010, 0, 2, 3);
    do_instr("sw",        7'b0100011, 3'b010, 0, 0, 0);
    do_instr("bge_taken", 7'b1100011, 3'b101, 1, 0, 0);
    do_instr("bge_not",   7'b1100011, 3'b101, 0, 0, 0);
    do_instr("jal",       7'b1101111, 3'b000, 0, 0, 0);
    do_instr("jalr",      7'b1100111, 3'b000, 0, 0, 0);
    do_instr("jalr_bad",  7'b1100111, 3'b001, 0, 0, 0);
    do_instr("zero",      7'b0000000, 3'b000, 0, 1, 0);
    do_instr("lbu_bad",   7'b0000011, 3'b110, 0, 0, 0);
    do_instr("lui",       7'b0110111, 3'b111, 0, 0, 0);

    // Reset in the middle of a stalled load access.
    instr_opcode = 7'b0000011;
    instr_funct3 = 3'b010;
    build(7'b0000011, 3'b010, 0, 0, 6);
    run_steps("lw_abort", 5, pcl_dummy);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("mid_mem before rst", obs, pk(3'd3, 0, 0, 1'b1, 0, 0, 0, 2'd0, 2'd0, 0));
    dmem_ack = 1'b1;
    apply_reset("mid_mem rst");
    dmem_ack = 1'b0;
    do_instr("after_abort", 7'b0110011, 3'b000, 0, 0, 0);

    // Random instruction stream.
    for (int i = 0; i < 60; i++) begin
      do_instr($sformatf("rnd%0d", i), ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
               rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
